// File: rtl/gate_check_pkg.sv
// Shared types and golden truth tables for the basic-gate checker.
package gate_check_pkg;

  localparam int NUM_GATES = 7;

  localparam int G_NOT  = 0;
  localparam int G_AND  = 1;
  localparam int G_NAND = 2;
  localparam int G_OR   = 3;
  localparam int G_NOR  = 4;
  localparam int G_XOR  = 5;
  localparam int G_XNOR = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  function automatic logic [NUM_GATES-1:0] expected_gates(
    input logic a,
    input logic b
  );
    logic [NUM_GATES-1:0] g;
    g         = '0;
    g[G_NOT]  = ~a;
    g[G_AND]  = a & b;
    g[G_NAND] = ~(a & b);
    g[G_OR]   = a | b;
    g[G_NOR]  = ~(a | b);
    g[G_XOR]  = a ^ b;
    g[G_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_expect_calc.sv
// Combinational golden model: expected gate outputs for the current stimulus.
module gate_expect_calc
  import gate_check_pkg::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_GATES-1:0] exp_o
);

  always_comb begin
    exp_o = expected_gates(a_i, b_i);
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps a/b through 00..11 and checks the 7 returned gate outputs.
// Define FIRST_FAIL_CAPTURE_EN to add first-mismatch capture ports.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  output logic                 a_out,
  output logic                 b_out,
  input  logic                 not_in,
  input  logic                 and_in,
  input  logic                 nand_in,
  input  logic                 or_in,
  input  logic                 nor_in,
  input  logic                 xor_in,
  input  logic                 xnor_in,
  output logic                 busy_op,
  output logic                 done_op,
  output logic                 pass_op,
  output logic [NUM_GATES-1:0] fail_mask_op,
`ifdef FIRST_FAIL_CAPTURE_EN
  output logic                 first_fail_vld_op,
  output logic [1:0]           first_fail_vec_op,
  output logic [NUM_GATES-1:0] first_fail_mask_op,
`endif
  output logic [CNT_W-1:0]     fail_cnt_op
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e               state_q;
  logic [SW-1:0]        settle_q;
  logic [PW-1:0]        pass_q;
  logic [1:0]           vec_q;
  logic [1:0]           vec_nx;
  logic                 a_q, b_q;
  logic                 busy_q, done_q, pass_q_o;
  logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;
  logic [CNT_W-1:0]     fail_cnt_q, fail_cnt_d;
  logic [NUM_GATES-1:0] obs, exp_g, mism;
  logic                 last_vec;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic                 ff_vld_q;
  logic [1:0]           ff_vec_q;
  logic [NUM_GATES-1:0] ff_mask_q;
`endif

  gate_expect_calc u_expect (
    .a_i   (a_q),
    .b_i   (b_q),
    .exp_o (exp_g)
  );

  assign obs = {xnor_in, xor_in, nor_in, or_in,
                nand_in, and_in, not_in};

  assign vec_nx   = vec_q + 2'd1;
  assign last_vec = (vec_q == 2'd3) &&
                    (int'(pass_q) == PASSES - 1);

  // Case inequality so X/Z on a returned gate counts as a mismatch.
  always_comb begin
    mism = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      mism[i] = (obs[i] !== exp_g[i]);
    end
    fail_mask_d = fail_mask_q | mism;
    fail_cnt_d  = fail_cnt_q;
    if ((|mism) && (fail_cnt_q != CNT_MAX)) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      pass_q      <= '0;
      vec_q       <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q_o    <= 1'b0;
      fail_mask_q <= '0;
      fail_cnt_q  <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_vld_q    <= 1'b0;
      ff_vec_q    <= '0;
      ff_mask_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            state_q     <= ST_APPLY;
            vec_q       <= '0;
            pass_q      <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b1;
            pass_q_o    <= 1'b0;
            fail_mask_q <= '0;
            fail_cnt_q  <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
            ff_vld_q    <= 1'b0;
            ff_vec_q    <= '0;
            ff_mask_q   <= '0;
`endif
          end
        end
        ST_APPLY: begin
          settle_q <= '0;
          if (SETTLE_CYCLES == 0) state_q <= ST_CHECK;
          else                    state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (int'(settle_q) == SETTLE_CYCLES - 1) begin
            state_q <= ST_CHECK;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        ST_CHECK: begin
          fail_mask_q <= fail_mask_d;
          fail_cnt_q  <= fail_cnt_d;
`ifdef FIRST_FAIL_CAPTURE_EN
          if ((|mism) && !ff_vld_q) begin
            ff_vld_q  <= 1'b1;
            ff_vec_q  <= {a_q, b_q};
            ff_mask_q <= mism;
          end
`endif
          if (last_vec) begin
            state_q  <= ST_DONE;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            pass_q_o <= (fail_cnt_d == '0);
          end else begin
            state_q <= ST_APPLY;
            vec_q   <= vec_nx;
            a_q     <= vec_nx[1];
            b_q     <= vec_nx[0];
            if (vec_q == 2'd3) pass_q <= pass_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign busy_op      = busy_q;
  assign done_op      = done_q;
  assign pass_op      = pass_q_o;
  assign fail_mask_op = fail_mask_q;
  assign fail_cnt_op  = fail_cnt_q;
`ifdef FIRST_FAIL_CAPTURE_EN
  assign first_fail_vld_op  = ff_vld_q;
  assign first_fail_vec_op  = ff_vec_q;
  assign first_fail_mask_op = ff_mask_q;
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker with a faultable gate model.
module tb_gate_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  int         fault = 0;

  logic       a, b, busy, done, pass;
  logic [6:0] mask;
  logic [7:0] cnt;
  logic       g_not, g_and, g_nand, g_or, g_nor, g_xor, g_xnor;

  logic       a2, b2, busy2, done2, pass2;
  logic [6:0] mask2;
  logic [3:0] cnt2;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic       ff_vld, ff_vld2;
  logic [1:0] ff_vec, ff_vec2;
  logic [6:0] ff_mask, ff_mask2;
`endif

  int passes = 0;
  int total  = 0;
  int edges;
  int dones;

  always #5 clk = ~clk;

  // Gate unit: 0 = correct, 1 = and stuck at 0, 2 = xor/xnor swapped
  always_comb begin
    g_not  = ~a;
    g_and  = (fault == 1) ? 1'b0 : (a & b);
    g_nand = ~(a & b);
    g_or   = a | b;
    g_nor  = ~(a | b);
    g_xor  = (fault == 2) ? ~(a ^ b) : (a ^ b);
    g_xnor = (fault == 2) ? (a ^ b) : ~(a ^ b);
  end

  gate_truth_table_checker dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .start_in     (start),
    .a_out        (a),
    .b_out        (b),
    .not_in       (g_not),
    .and_in       (g_and),
    .nand_in      (g_nand),
    .or_in        (g_or),
    .nor_in       (g_nor),
    .xor_in       (g_xor),
    .xnor_in      (g_xnor),
    .busy_op      (busy),
    .done_op      (done),
    .pass_op      (pass),
    .fail_mask_op (mask),
`ifdef FIRST_FAIL_CAPTURE_EN
    .first_fail_vld_op  (ff_vld),
    .first_fail_vec_op  (ff_vec),
    .first_fail_mask_op (ff_mask),
`endif
    .fail_cnt_op  (cnt)
  );

  gate_truth_table_checker #(
    .SETTLE_CYCLES (2),
    .PASSES        (100),
    .CNT_W         (4)
  ) dut2 (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .start_in     (start2),
    .a_out        (a2),
    .b_out        (b2),
    .not_in       (1'b0),
    .and_in       (1'b0),
    .nand_in      (1'b0),
    .or_in        (1'b0),
    .nor_in       (1'b0),
    .xor_in       (1'b0),
    .xnor_in      (1'b0),
    .busy_op      (busy2),
    .done_op      (done2),
    .pass_op      (pass2),
    .fail_mask_op (mask2),
`ifdef FIRST_FAIL_CAPTURE_EN
    .first_fail_vld_op  (ff_vld2),
    .first_fail_vec_op  (ff_vec2),
    .first_fail_mask_op (ff_mask2),
`endif
    .fail_cnt_op  (cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start for one edge, return edges from accept to done (-1 on timeout)
  task automatic run(output int n);
    n = -1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_a", 32'(a), 0);
    chk("rst_b", 32'(b), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_mask", 32'(mask), 0);
    chk("rst_cnt", 32'(cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // T1: correct gate unit
    fault = 0;
    run(edges);
    chk("t1_lat", 32'(edges), 17);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_mask", 32'(mask), 0);
    chk("t1_cnt", 32'(cnt), 0);
    chk("t1_busy", 32'(busy), 0);

    // T2: and stuck at 0, only vector 11 differs
    fault = 1;
    run(edges);
    chk("t2_lat", 32'(edges), 17);
    chk("t2_mask", 32'(mask), 32'h02);
    chk("t2_cnt", 32'(cnt), 1);
    chk("t2_pass", 32'(pass), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("t2_ffvld", 32'(ff_vld), 1);
    chk("t2_ffvec", 32'(ff_vec), 32'h3);
    chk("t2_ffmask", 32'(ff_mask), 32'h02);
`endif

    // T3: xor/xnor swapped, every vector differs
    fault = 2;
    run(edges);
    chk("t3_mask", 32'(mask), 32'h60);
    chk("t3_cnt", 32'(cnt), 4);
    chk("t3_pass", 32'(pass), 0);

    // T4: start clears results; mid-run starts ignored
    fault = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    chk("t4_clr_mask", 32'(mask), 0);
    chk("t4_clr_cnt", 32'(cnt), 0);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_a0", 32'({a, b}), 0);
    dones = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 12) chk("t4_vec3", 32'({a, b}), 32'h3);
      start = (k == 3 || k == 9);
      if (done) dones++;
    end
    start = 1'b0;
    chk("t4_dones", 32'(dones), 1);
    chk("t4_pass", 32'(pass), 1);

    // T5: reset mid-run
    fault = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_pre_mask", 32'(mask), 32'h60);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ab", 32'({a, b}), 0);
    chk("t5_mask", 32'(mask), 0);
    chk("t5_cnt", 32'(cnt), 0);
    chk("t5_pass", 32'(pass), 0);
    dones = 0;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("t5_nodone", 32'(dones), 0);
    fault = 0;
    run(edges);
    chk("t5_lat", 32'(edges), 17);
    chk("t5_rpass", 32'(pass), 1);

    // T6: 100 passes with every gate input low, counter saturates
    edges = -1;
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    @(negedge clk) start2 = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done2) begin
        edges = k;
        break;
      end
    end
    chk("t6_lat", 32'(edges), 1601);
    chk("t6_cnt", 32'(cnt2), 15);
    chk("t6_mask", 32'(mask2), 32'h7F);
    chk("t6_pass", 32'(pass2), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
